// File: rtl/log_reader_pkg.sv
// Shared definitions for the log RAM drain engine: FSM state encoding and
// the log entry width.
package log_reader_pkg;

  localparam int LOG_DATA_WIDTH = 37;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_CAP  = 3'd2,
    ST_SEND = 3'd3,
    ST_CSUM = 3'd4,
    ST_CLR  = 3'd5,
    ST_DONE = 3'd6
  } state_e;

endpackage

// File: rtl/log_reader_if.sv
// Valid/ready stream carrying drained log entries. The drain engine is the
// master; the attestation/report consumer is the slave.
interface log_reader_if #(
  parameter int DATA_WIDTH = log_reader_pkg::LOG_DATA_WIDTH
) ();

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/log_reader.sv
// Drain engine for the entry log RAM. Reads entries 0..cnt-1 through the RAM
// read port, streams them on the out_if valid/ready interface, then pulses a
// one-cycle RAM clear followed by a one-cycle done.
// Optional feature: define LOG_READER_CSUM_EN to append an XOR trailer word.
module log_reader
  import log_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = LOG_DATA_WIDTH,
  parameter int DEPTH      = ADDR_WIDTH ** 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_entries,
  input  logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  ram_clr,
  log_reader_if.master          out_if,
  output logic                  busy,
  output logic                  done
);

  // One extra bit so that cnt == DEPTH is representable without wrap.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         ptr_inc_s;
  logic [CW-1:0]         num_ext_s;
  logic                  ram_re_q, ram_re_d;
  logic [ADDR_WIDTH-1:0] ram_rd_addr_q, ram_rd_addr_d;
  logic                  ram_clr_q, ram_clr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef LOG_READER_CSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

  // Next-state and next-output computation; outputs are derived from the
  // next state so every port is driven straight from a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
`ifdef LOG_READER_CSUM_EN
    csum_d     = csum_q;
`endif
    ptr_inc_s  = ptr_q + CW'(1);
    num_ext_s  = CW'(num_entries);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d = (num_ext_s > DEPTH_C) ? DEPTH_C : num_ext_s;
          ptr_d = '0;
`ifdef LOG_READER_CSUM_EN
          csum_d = '0;
          if (cnt_d == '0) begin
            // Empty drain still emits a zero trailer.
            state_d    = ST_CSUM;
            out_data_d = '0;
            out_last_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
`else
          state_d = (cnt_d == '0) ? ST_CLR : ST_REQ;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // A concurrent logger write blocks the read; hold the request.
        state_d = ram_we ? ST_REQ : ST_CAP;
      end
      ST_CAP: begin
        if (ram_we) begin
          // Read data is corrupted by the collision; retry the same entry.
          state_d = ST_REQ;
        end else begin
          state_d    = ST_SEND;
          out_data_d = ram_rd_data;
`ifdef LOG_READER_CSUM_EN
          out_last_d = 1'b0;
`else
          out_last_d = (ptr_inc_s == cnt_q);
`endif
        end
      end
      ST_SEND: begin
        if (out_if.out_ready) begin
          out_last_d = 1'b0;
`ifdef LOG_READER_CSUM_EN
          csum_d = csum_q ^ out_data_q;
`endif
          if (ptr_inc_s == cnt_q) begin
`ifdef LOG_READER_CSUM_EN
            state_d    = ST_CSUM;
            out_data_d = csum_q ^ out_data_q;
            out_last_d = 1'b1;
`else
            state_d = ST_CLR;
`endif
          end else begin
            // Only advance when another entry follows, so ptr stays <= DEPTH-1.
            ptr_d   = ptr_inc_s;
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_CSUM: begin
        if (out_if.out_ready) begin
          state_d    = ST_CLR;
          out_last_d = 1'b0;
        end else begin
          state_d = ST_CSUM;
        end
      end
      ST_CLR:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ram_re_d      = (state_d == ST_REQ) || (state_d == ST_CAP);
    ram_rd_addr_d = ram_re_d ? ptr_d[ADDR_WIDTH-1:0] : ram_rd_addr_q;
    ram_clr_d     = (state_d == ST_CLR);
    out_valid_d   = (state_d == ST_SEND) || (state_d == ST_CSUM);
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
  end

  // Drain FSM and registered outputs; synchronous reset aborts any drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      ptr_q         <= '0;
      ram_re_q      <= 1'b0;
      ram_rd_addr_q <= '0;
      ram_clr_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef LOG_READER_CSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      ram_re_q      <= ram_re_d;
      ram_rd_addr_q <= ram_rd_addr_d;
      ram_clr_q     <= ram_clr_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef LOG_READER_CSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  assign ram_re           = ram_re_q;
  assign ram_rd_addr      = ram_rd_addr_q;
  assign ram_clr          = ram_clr_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_last  = out_last_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_log_reader.sv
// Directed self-checking bench for log_reader with a behavioural log RAM.
// Builds for both the default and the LOG_READER_CSUM_EN configuration.
module tb_log_reader;
  import log_reader_pkg::*;

`ifdef LOG_READER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] num_entries;
  logic        ram_re;
  logic [15:0] ram_rd_addr;
  logic [36:0] ram_rd_data;
  logic        ram_clr;
  logic        busy;
  logic        done;

  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [36:0] wr_data;

  logic [36:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;
  int re_cnt   = 0;
  int clr_cnt  = 0;
  int done_cnt = 0;
  logic [36:0] got_data [$];
  bit          got_last [$];

  log_reader_if #(.DATA_WIDTH(37)) out_if ();

  log_reader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_entries (num_entries),
    .ram_we      (wr_en),
    .ram_re      (ram_re),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .ram_clr     (ram_clr),
    .out_if      (out_if.slave),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Log RAM model: registered read, zero unless re=1 and we=0, one-cycle clear.
  always @(posedge clk) begin
    ram_rd_data <= (ram_re && !wr_en) ? mem[ram_rd_addr[7:0]] : 37'h0;
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 37'h0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Observer: records accepted words and counts read/clear/done cycles.
  always @(posedge clk) begin
    if (ram_re)  re_cnt++;
    if (ram_clr) clr_cnt++;
    if (done)    done_cnt++;
    if (out_if.out_valid && out_if.out_ready) begin
      got_data.push_back(out_if.out_data);
      got_last.push_back(out_if.out_last);
    end
  end

  task automatic wr(input int a, input logic [36:0] d);
    wr_en = 1'b1; wr_addr = a[7:0]; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic kick(input int n);
    start = 1'b1; num_entries = n[15:0];
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
    ok = (done_cnt != d0);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    for (int i = 0; i < budget && !out_if.out_valid; i++) @(negedge clk);
    ok = out_if.out_valid;
  endtask

  task automatic test_reset;
    n_checks++;
    if ({ram_re, ram_clr, out_if.out_valid, out_if.out_last, busy, done} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 000000",
        {ram_re, ram_clr, out_if.out_valid, out_if.out_last, busy, done});
    end
    n_checks++;
    if (ram_rd_addr !== 16'h0 || out_if.out_data !== 37'h0) begin
      n_fail++; $display("FAIL reset_data addr %h data %h want 0", ram_rd_addr, out_if.out_data);
    end
  endtask

  task automatic test_basic;
    logic [36:0] exp [$];
    int s0 = got_data.size(), c0 = clr_cnt, r0 = re_cnt;
    bit ok;
    logic nz = 1'b0;
    for (int i = 0; i < 4; i++) wr(i, 37'(i + 1));
    out_if.out_ready = 1'b1;
    exp = '{37'h1, 37'h2, 37'h3, 37'h4};
    if (CSUM) exp.push_back(37'h4);
    kick(4);
    n_checks++;
    if (ram_re !== 1'b1 || ram_rd_addr !== 16'h0 || busy !== 1'b1 || out_if.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_req re %b addr %h busy %b valid %b want 1 0 1 0",
        ram_re, ram_rd_addr, busy, out_if.out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (out_if.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_cap valid %b want 0", out_if.out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (out_if.out_valid !== 1'b1 || out_if.out_data !== 37'h1) begin
      n_fail++; $display("FAIL basic_first valid %b data %h want 1 1", out_if.out_valid, out_if.out_data);
    end
    wait_done(60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout done %b want 1", ok); end
    n_checks++;
    if (got_data.size() - s0 != exp.size()) begin
      n_fail++; $display("FAIL basic_count got %0d want %0d", got_data.size() - s0, exp.size());
    end
    for (int i = 0; i < exp.size() && s0 + i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[s0+i] !== exp[i] || got_last[s0+i] !== (i == exp.size() - 1)) begin
        n_fail++; $display("FAIL basic_word%0d got %h/%b want %h/%b", i, got_data[s0+i],
          got_last[s0+i], exp[i], (i == exp.size() - 1));
      end
    end
    n_checks++;
    if (clr_cnt - c0 != 1) begin n_fail++; $display("FAIL basic_clr got %0d want 1", clr_cnt - c0); end
    n_checks++;
    if (re_cnt - r0 != 8) begin n_fail++; $display("FAIL basic_reads got %0d want 8", re_cnt - r0); end
    for (int i = 0; i < 4; i++) if (mem[i] !== 37'h0) nz = 1'b1;
    n_checks++;
    if (nz !== 1'b0) begin n_fail++; $display("FAIL basic_ramclr nonzero %b want 0", nz); end
  endtask

  task automatic test_stall;
    logic [36:0] exp [$];
    int s0 = got_data.size(), r0 = re_cnt, r1;
    bit ok;
    wr(0, 37'h1A); wr(1, 37'h2B);
    exp = '{37'h1A, 37'h2B};
    if (CSUM) exp.push_back(37'h31);
    out_if.out_ready = 1'b0;
    kick(2);
    for (int w = 0; w < 2; w++) begin
      wait_valid(20, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL stall_valid%0d got %b want 1", w, ok); end
      r1 = re_cnt;
      for (int c = 0; c < 5; c++) begin
        n_checks++;
        if (out_if.out_valid !== 1'b1 || out_if.out_data !== exp[w] ||
            out_if.out_last !== (w == 1 && !CSUM)) begin
          n_fail++; $display("FAIL stall_hold w%0d c%0d valid %b data %h last %b want 1 %h %b", w, c,
            out_if.out_valid, out_if.out_data, out_if.out_last, exp[w], (w == 1 && !CSUM));
        end
        @(negedge clk);
      end
      n_checks++;
      if (re_cnt != r1) begin n_fail++; $display("FAIL stall_reads got %0d want %0d", re_cnt, r1); end
      out_if.out_ready = 1'b1;
      @(negedge clk);
      out_if.out_ready = 1'b0;
    end
    out_if.out_ready = 1'b1;
    wait_done(40, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall_timeout done %b want 1", ok); end
    n_checks++;
    if (got_data.size() - s0 != exp.size()) begin
      n_fail++; $display("FAIL stall_count got %0d want %0d", got_data.size() - s0, exp.size());
    end
    for (int i = 0; i < exp.size() && s0 + i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[s0+i] !== exp[i]) begin
        n_fail++; $display("FAIL stall_word%0d got %h want %h", i, got_data[s0+i], exp[i]);
      end
    end
    n_checks++;
    if (re_cnt - r0 != 4) begin n_fail++; $display("FAIL stall_totreads got %0d want 4", re_cnt - r0); end
  endtask

  task automatic test_collision;
    logic [36:0] exp [$];
    int s0, r0;
    bit ok;
    wr(0, 37'h1); wr(1, 37'h2);
    exp = '{37'h1, 37'h2};
    if (CSUM) exp.push_back(37'h3);
    s0 = got_data.size(); r0 = re_cnt;
    out_if.out_ready = 1'b1;
    kick(2);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 8'd200; wr_data = 37'h1F;
    @(negedge clk);
    wr_en = 1'b0;
    n_checks++;
    if (ram_re !== 1'b1 || ram_rd_addr !== 16'h0 || out_if.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL coll_retry re %b addr %h valid %b want 1 0 0",
        ram_re, ram_rd_addr, out_if.out_valid);
    end
    wait_done(40, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL coll_timeout done %b want 1", ok); end
    n_checks++;
    if (got_data.size() - s0 != exp.size()) begin
      n_fail++; $display("FAIL coll_count got %0d want %0d", got_data.size() - s0, exp.size());
    end
    for (int i = 0; i < exp.size() && s0 + i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[s0+i] !== exp[i] || got_last[s0+i] !== (i == exp.size() - 1)) begin
        n_fail++; $display("FAIL coll_word%0d got %h/%b want %h", i, got_data[s0+i], got_last[s0+i], exp[i]);
      end
    end
    n_checks++;
    if (re_cnt - r0 != 6) begin n_fail++; $display("FAIL coll_reads got %0d want 6", re_cnt - r0); end
  endtask

  task automatic test_zero;
    int s0 = got_data.size(), c0 = clr_cnt, r0 = re_cnt;
    bit ok;
    out_if.out_ready = 1'b1;
    kick(0);
    wait_done(20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL zero_timeout done %b want 1", ok); end
    n_checks++;
    if (got_data.size() - s0 != (CSUM ? 1 : 0)) begin
      n_fail++; $display("FAIL zero_count got %0d want %0d", got_data.size() - s0, CSUM ? 1 : 0);
    end
    if (CSUM && got_data.size() > s0) begin
      n_checks++;
      if (got_data[s0] !== 37'h0 || got_last[s0] !== 1'b1) begin
        n_fail++; $display("FAIL zero_trailer got %h/%b want 0/1", got_data[s0], got_last[s0]);
      end
    end
    n_checks++;
    if (clr_cnt - c0 != 1 || re_cnt != r0) begin
      n_fail++; $display("FAIL zero_side clr %0d reads %0d want 1 0", clr_cnt - c0, re_cnt - r0);
    end
  endtask

  task automatic test_reset_mid;
    int s0, c0, d0;
    bit ok;
    logic bad = 1'b0;
    for (int i = 0; i < 4; i++) wr(i, 37'(17 + i));
    s0 = got_data.size(); c0 = clr_cnt; d0 = done_cnt;
    out_if.out_ready = 1'b0;
    kick(4);
    wait_valid(20, ok);
    out_if.out_ready = 1'b1;
    @(negedge clk);
    out_if.out_ready = 1'b0;
    wait_valid(20, ok);
    n_checks++;
    if (!ok || out_if.out_data !== 37'h12) begin
      n_fail++; $display("FAIL rmid_send2 valid %b data %h want 1 12", ok, out_if.out_data);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ram_re, ram_clr, out_if.out_valid, out_if.out_last, busy, done} !== 6'b0 ||
        out_if.out_data !== 37'h0 || ram_rd_addr !== 16'h0) begin
      n_fail++; $display("FAIL rmid_outs ctrl %b data %h addr %h want 0",
        {ram_re, ram_clr, out_if.out_valid, out_if.out_last, busy, done}, out_if.out_data, ram_rd_addr);
    end
    reset = 1'b0;
    out_if.out_ready = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (clr_cnt != c0 || done_cnt != d0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rmid_abort clr %0d done %0d busy %b want 0 0 0", clr_cnt - c0, done_cnt - d0, busy);
    end
    for (int i = 0; i < 4; i++) if (mem[i] !== 37'(17 + i)) bad = 1'b1;
    n_checks++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL rmid_ram altered %b want 0", bad); end
    n_checks++;
    if (got_data.size() - s0 != 1) begin
      n_fail++; $display("FAIL rmid_words got %0d want 1", got_data.size() - s0);
    end
  endtask

  task automatic test_clamp;
    logic [36:0] exp [$];
    logic [36:0] x = 37'h0;
    int s0, c0;
    bit ok;
    for (int i = 0; i < 256; i++) begin
      wr(i, 37'h100 + 37'(i));
      exp.push_back(37'h100 + 37'(i));
      x = x ^ (37'h100 + 37'(i));
    end
    if (CSUM) exp.push_back(x);
    s0 = got_data.size(); c0 = clr_cnt;
    out_if.out_ready = 1'b1;
    kick(300);
    wait_done(256 * 3 + 40, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL clamp_timeout done %b want 1", ok); end
    n_checks++;
    if (got_data.size() - s0 != exp.size()) begin
      n_fail++; $display("FAIL clamp_count got %0d want %0d", got_data.size() - s0, exp.size());
    end
    for (int i = 0; i < exp.size() && s0 + i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[s0+i] !== exp[i] || got_last[s0+i] !== (i == exp.size() - 1)) begin
        n_fail++; $display("FAIL clamp_word%0d got %h/%b want %h", i, got_data[s0+i], got_last[s0+i], exp[i]);
      end
    end
    n_checks++;
    if (clr_cnt - c0 != 1) begin n_fail++; $display("FAIL clamp_clr got %0d want 1", clr_cnt - c0); end
  endtask

`ifdef LOG_READER_CSUM_EN
  task automatic test_csum;
    logic [36:0] exp [$];
    int s0;
    bit ok;
    wr(0, 37'h5); wr(1, 37'h3);
    exp = '{37'h5, 37'h3, 37'h6};
    s0 = got_data.size();
    out_if.out_ready = 1'b1;
    kick(2);
    wait_done(40, ok);
    n_checks++;
    if (!ok || got_data.size() - s0 != 3) begin
      n_fail++; $display("FAIL csum_count done %b got %0d want 3", ok, got_data.size() - s0);
    end
    for (int i = 0; i < 3 && s0 + i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[s0+i] !== exp[i] || got_last[s0+i] !== (i == 2)) begin
        n_fail++; $display("FAIL csum_word%0d got %h/%b want %h", i, got_data[s0+i], got_last[s0+i], exp[i]);
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; num_entries = 16'h0;
    wr_en = 1'b0; wr_addr = 8'h0; wr_data = 37'h0;
    out_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_collision();
    test_zero();
    test_reset_mid();
    test_clamp();
`ifdef LOG_READER_CSUM_EN
    test_csum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
